// File: rtl/pcp_imem_loader.sv
// Instruction-memory loader for the PCP core.
// Assembles 75-bit instructions from three 32-bit host beats and writes
// them to consecutive instruction-memory addresses from a base address.
// Range-checked before the first beat, so the write address never wraps.
module pcp_imem_loader (
    input  logic        clock,
    input  logic        reset,
    input  logic        cfg_start,
    input  logic [9:0]  cfg_base_addr,
    input  logic [10:0] cfg_count,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [9:0]  imem_addr,
    output logic [74:0] imem_data,
    output logic        imem_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD0,
        LOAD1,
        LOAD2,
        FIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [9:0]  wr_ptr;
    logic [10:0] remaining;
    logic [63:0] partial;
    logic [10:0] end_addr;
    logic        range_bad;
    logic        xfer;

    // One past the last address the requested load would touch.
    // 1023 + 1024 still fits in 11 bits, so this compare cannot overflow.
    assign end_addr  = {1'b0, cfg_base_addr} + cfg_count;
    assign range_bad = (end_addr > 11'd1024);
    assign xfer      = s_valid & s_ready;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded outputs.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (cfg_start) begin
                    if (cfg_count == 11'd0 || range_bad) begin
                        state_next = FIN;
                    end else begin
                        state_next = LOAD0;
                    end
                end
            end
            LOAD0: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    state_next = LOAD1;
                end
            end
            LOAD1: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    state_next = LOAD2;
                end
            end
            LOAD2: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (remaining == 11'd1) begin
                        state_next = FIN;
                    end else begin
                        state_next = LOAD0;
                    end
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: configuration capture, partial-word assembly, memory write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= 10'd0;
            remaining <= 11'd0;
            partial   <= 64'd0;
            imem_addr <= 10'd0;
            imem_data <= 75'd0;
            imem_we   <= 1'b0;
            err       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        err       <= range_bad;
                        wr_ptr    <= cfg_base_addr;
                        remaining <= cfg_count;
                    end
                end
                LOAD0: begin
                    if (xfer) begin
                        partial[31:0] <= s_data;
                    end
                end
                LOAD1: begin
                    if (xfer) begin
                        partial[63:32] <= s_data;
                    end
                end
                LOAD2: begin
                    if (xfer) begin
                        imem_we   <= 1'b1;
                        imem_data <= {s_data[10:0], partial};
                        imem_addr <= wr_ptr;
                        wr_ptr    <= wr_ptr + 10'd1;
                        remaining <= remaining - 11'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/pcp_imem_loader.md
PCP_IMEM_LOADER -- requirements
Module: pcp_imem_loader

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports listed as: name, direction, width, meaning.
REQ-002 clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cfg_start  input  1  one-cycle load request; sampled only in IDLE.
REQ-005 cfg_base_addr  input  10  first instruction-memory address, sampled with cfg_start.
REQ-006 cfg_count  input  11  number of 75-bit instructions to load (0..1024), sampled with cfg_start.
REQ-007 s_data  input  32  host beat data.
REQ-008 s_valid  input  1  host beat valid.
REQ-009 s_ready  output  1  loader can accept a beat.
REQ-010 imem_addr  output  10  instruction-memory write address, driving the write-port address.
REQ-011 imem_data  output  75  instruction-memory write data.
REQ-012 imem_we  output  1  instruction-memory write enable, one cycle per instruction.
REQ-013 busy  output  1  a load is in progress; core fetch is held off while high.
REQ-014 done  output  1  one-cycle pulse at the end of a load, including zero-length and error loads.
REQ-015 err  output  1  sticky range error; cleared by the next accepted cfg_start.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD0, LOAD1, LOAD2 and FIN.
REQ-017 A beat SHALL transfer only in a cycle with s_valid=1 and s_ready=1.
REQ-018 s_ready SHALL be 1 in LOAD0, LOAD1 and LOAD2, and 0 in IDLE and FIN.
REQ-019 LOAD0 SHALL capture s_data into bits [31:0] of the instruction; LOAD1 into [63:32]; LOAD2 bits s_data[10:0] into [74:64].
REQ-020 s_data[31:11] SHALL be ignored in LOAD2.
REQ-021 Each LOADn state SHALL advance to the next state only on a transfer; without a transfer it SHALL hold its state and its partial word.
REQ-022 On a LOAD2 transfer, the next cycle SHALL drive imem_we=1 with imem_data equal to the assembled word and imem_addr equal to the current write pointer.
REQ-023 The write pointer SHALL be loaded with cfg_base_addr at start and SHALL increment by 1 after each write.
REQ-024 imem_we SHALL be high for exactly one cycle per instruction and SHALL be 0 in all other cycles.
REQ-025 imem_addr and imem_data SHALL hold their last values when imem_we=0.
REQ-026 Write latency SHALL be 1 cycle from the LOAD2 transfer to imem_we.
REQ-027 After a LOAD2 transfer that is not the last instruction, the FSM SHALL go to LOAD0, so the next beat may transfer in the same cycle as imem_we.
REQ-028 After the LOAD2 transfer of the last instruction, the FSM SHALL go to FIN, so that the final imem_we coincides with FIN.
REQ-029 FIN SHALL last exactly one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-030 busy SHALL be 1 in LOAD0, LOAD1, LOAD2 and FIN, and 0 in IDLE.
REQ-031 When cfg_start is accepted in IDLE, err SHALL be cleared.
REQ-032 If cfg_count=0, the FSM SHALL go to FIN with no imem_we.
REQ-033 If cfg_base_addr+cfg_count>1024 (11-bit compare), the FSM SHALL set err=1 and go to FIN with no writes; the address never wraps.
REQ-034 Otherwise the FSM SHALL go to LOAD0 with the remaining-instruction counter set to cfg_count.
REQ-035 cfg_start outside IDLE SHALL be ignored.
REQ-036 Host beats presented while s_ready=0 SHALL not be consumed.
REQ-037 For a load of 1024 instructions from base 0, the final write SHALL go to address 1023, and the pointer overflow to 0 SHALL be harmless because the FSM is already in FIN.

Reset
REQ-038 While reset=1, the FSM SHALL be IDLE, and s_ready, imem_we, busy, done and err SHALL be 0.
REQ-039 While reset=1, imem_addr, imem_data, the write pointer, the counter and the partial word SHALL be 0.
REQ-040 A reset asserted mid-load SHALL abort the load immediately with no further writes; instructions already written remain in memory.
REQ-041 Release of reset SHALL take effect on the next clock edge.

Verification
REQ-042 Start base=0x010, count=2; beats 0x11111111, 0x22222222, 0x7FF, 0x33333333, 0x44444444, 0x001 back-to-back -> imem_we at addr 0x010 with data 0x7FF_22222222_11111111, then at addr 0x011 with data 0x001_44444444_33333333; done pulses with the second write; busy falls the following cycle.
REQ-043 Same load with s_valid toggling 1-0-1 -> identical writes, and exactly 6 transfers counted.
REQ-044 Start base=0x3FF, count=2 -> err=1, done pulse, no imem_we, s_ready never 1; a later start base=0x3FF, count=1 clears err and writes addr 0x3FF.
REQ-045 Start count=0 -> done pulse 1 cycle after start, no writes, err=0; cfg_start pulsed during an active load -> ignored.
REQ-046 Reset asserted after 4 beats of a 3-instruction load -> exactly one write observed, all outputs 0 during reset; a new start after release loads correctly.
